// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: shares the parking controller's single car-event port
// between NUM_GATES entry/exit lanes. Round-robin grant, vacancy check for
// entering cars, one strobe per served request, admit/deny reported to the gate.
//
// Gate handshake: a gate raises gate_req (valid) and holds it together with
// gate_is_uni/gate_is_exit until it sees gate_ack (completion) for exactly one
// cycle; it drops gate_req at the edge that ends that ack cycle. The arbiter
// samples request and attributes only in IDLE. The gate being acked is masked
// out of that IDLE cycle's arbitration, so a still-high request is not served twice.
module parking_gate_arbiter #(
  parameter int NUM_GATES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] gate_req,
  input  logic [NUM_GATES-1:0] gate_is_uni,
  input  logic [NUM_GATES-1:0] gate_is_exit,
  output logic [NUM_GATES-1:0] gate_ack,
  output logic [NUM_GATES-1:0] gate_admit,
  output logic                 car_entered,
  output logic                 is_uni_car_entered,
  output logic                 car_exited,
  output logic                 is_uni_car_exited,
  input  logic                 uni_is_vacated_space,
  input  logic                 is_vacated_space,
  output logic                 busy,
  output logic [CNT_W-1:0]     denied_count
);

  localparam int IDW = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t               r_state;
  logic [IDW-1:0]       r_rr_ptr;
  logic [IDW-1:0]       r_id;
  logic                 r_is_uni;
  logic                 r_is_exit;
  logic                 r_admit;
  logic                 r_busy;
  logic [CNT_W-1:0]     r_denied;
  logic [NUM_GATES-1:0] r_gate_ack;
  logic [NUM_GATES-1:0] r_gate_admit;
  logic                 r_car_entered;
  logic                 r_uni_entered;
  logic                 r_car_exited;
  logic                 r_uni_exited;

  logic [NUM_GATES-1:0] w_req;
  logic                 w_found;
  logic [IDW-1:0]       w_win_id;

  // Round-robin search starting at r_rr_ptr; the gate currently acked is excluded.
  always_comb begin
    w_req    = gate_req & ~r_gate_ack;
    w_found  = 1'b0;
    w_win_id = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      if (!w_found && w_req[(int'(r_rr_ptr) + i) % NUM_GATES]) begin
        w_found  = 1'b1;
        w_win_id = IDW'((int'(r_rr_ptr) + i) % NUM_GATES);
      end
    end
  end

  // Transaction FSM with all outputs registered; strobes and acks default low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_id          <= '0;
      r_is_uni      <= 1'b0;
      r_is_exit     <= 1'b0;
      r_admit       <= 1'b0;
      r_busy        <= 1'b0;
      r_denied      <= '0;
      r_gate_ack    <= '0;
      r_gate_admit  <= '0;
      r_car_entered <= 1'b0;
      r_uni_entered <= 1'b0;
      r_car_exited  <= 1'b0;
      r_uni_exited  <= 1'b0;
    end else begin
      r_gate_ack    <= '0;
      r_gate_admit  <= '0;
      r_car_entered <= 1'b0;
      r_uni_entered <= 1'b0;
      r_car_exited  <= 1'b0;
      r_uni_exited  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id      <= w_win_id;
            r_is_uni  <= gate_is_uni[w_win_id];
            r_is_exit <= gate_is_exit[w_win_id];
            r_busy    <= 1'b1;
            r_state   <= S_ISSUE;
          end else begin
            r_busy    <= 1'b0;
          end
        end
        S_ISSUE: begin
          // Exits always pass; entries need a free slot of the matching class.
          r_admit <= r_is_exit | (r_is_uni ? uni_is_vacated_space : is_vacated_space);
          r_busy  <= 1'b1;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_admit) begin
            if (r_is_exit) begin
              r_car_exited  <= 1'b1;
              r_uni_exited  <= r_is_uni;
            end else begin
              r_car_entered <= 1'b1;
              r_uni_entered <= r_is_uni;
            end
          end else if (r_denied != {CNT_W{1'b1}}) begin
            r_denied <= r_denied + 1'b1;
          end
          r_busy  <= 1'b1;
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_gate_ack[r_id]   <= 1'b1;
          r_gate_admit[r_id] <= r_admit;
          r_rr_ptr <= (r_id == IDW'(NUM_GATES - 1)) ? '0 : r_id + 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gate_ack           = r_gate_ack;
  assign gate_admit         = r_gate_admit;
  assign car_entered        = r_car_entered;
  assign is_uni_car_entered = r_uni_entered;
  assign car_exited         = r_car_exited;
  assign is_uni_car_exited  = r_uni_exited;
  assign busy               = r_busy;
  assign denied_count       = r_denied;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter (4 gates, 4-bit denied counter).
module tb_parking_gate_arbiter;

  localparam int NG = 4;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [NG-1:0] gate_req;
  logic [NG-1:0] gate_is_uni;
  logic [NG-1:0] gate_is_exit;
  logic [NG-1:0] gate_ack;
  logic [NG-1:0] gate_admit;
  logic          car_entered;
  logic          is_uni_car_entered;
  logic          car_exited;
  logic          is_uni_car_exited;
  logic          uni_is_vacated_space;
  logic          is_vacated_space;
  logic          busy;
  logic [CW-1:0] denied_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [NG-1:0] exp_q[$];

  parking_gate_arbiter #(.NUM_GATES(NG), .CNT_W(CW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .gate_req             (gate_req),
    .gate_is_uni          (gate_is_uni),
    .gate_is_exit         (gate_is_exit),
    .gate_ack             (gate_ack),
    .gate_admit           (gate_admit),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .busy                 (busy),
    .denied_count         (denied_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Checking task: every comparison goes through here.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Driver: one full transaction on gate g, checked cycle by cycle.
  // Called just after a rising edge with the DUT idle.
  task automatic serve(input int g, input logic uni, input logic ex, input logic exp_adm);
    logic          exp_ent;
    logic          exp_ext;
    logic [NG-1:0] one_hot;
    int            busy_n;
    one_hot      = '0;
    one_hot[g]   = 1'b1;
    gate_req     = one_hot;
    gate_is_uni  = uni ? one_hot : '0;
    gate_is_exit = ex  ? one_hot : '0;
    exp_ent      = exp_adm & ~ex;
    exp_ext      = exp_adm & ex;
    busy_n       = 0;
    // grant edge -> ISSUE
    @(posedge clk); #1;
    if (busy) busy_n++;
    chk("strobe_issue", {car_entered, car_exited}, 0);
    chk("ack_issue", gate_ack, 0);
    // SETTLE
    @(posedge clk); #1;
    if (busy) busy_n++;
    chk("strobe_settle", {car_entered, car_exited}, 0);
    // strobe cycle
    @(posedge clk); #1;
    if (busy) busy_n++;
    chk("car_entered", car_entered, exp_ent);
    chk("is_uni_car_entered", is_uni_car_entered, exp_ent & uni);
    chk("car_exited", car_exited, exp_ext);
    chk("is_uni_car_exited", is_uni_car_exited, exp_ext & uni);
    chk("ack_early", gate_ack, 0);
    // ack cycle
    @(posedge clk); #1;
    chk("gate_ack", gate_ack, one_hot);
    chk("gate_admit", gate_admit, exp_adm ? one_hot : '0);
    chk("strobe_after", {car_entered, car_exited}, 0);
    chk("busy_in_ack_cycle", busy, 0);
    chk("busy_cycles", busy_n, 3);
    gate_req = '0;
    // ack is one cycle and the request is not served again
    @(posedge clk); #1;
    chk("ack_pulse", gate_ack, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int cyc;
    int prev;
    int n_ack;
    gate_req             = '0;
    gate_is_uni          = '0;
    gate_is_exit         = '0;
    uni_is_vacated_space = 1'b0;
    is_vacated_space     = 1'b0;
    reset                = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    // reset state
    chk("rst_ack", gate_ack, 0);
    chk("rst_admit", gate_admit, 0);
    chk("rst_strobes", {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_denied", denied_count, 0);
    do_reset();

    // single regular entry on gate 2
    is_vacated_space = 1'b1; uni_is_vacated_space = 1'b0;
    serve(2, 1'b0, 1'b0, 1'b1);
    chk("denied_after_admit", denied_count, 0);

    // university entry on gate 1 with no university slot (regular slot free)
    is_vacated_space = 1'b1; uni_is_vacated_space = 1'b0;
    serve(1, 1'b1, 1'b0, 1'b0);
    chk("denied_one", denied_count, 1);

    // university exit on gate 3 with a full lot
    is_vacated_space = 1'b0; uni_is_vacated_space = 1'b0;
    serve(3, 1'b1, 1'b1, 1'b1);
    chk("exit_not_denied", denied_count, 1);

    // regular entry on gate 0: only a university slot is free
    is_vacated_space = 1'b0; uni_is_vacated_space = 1'b1;
    serve(0, 1'b0, 1'b0, 1'b0);
    chk("denied_two", denied_count, 2);

    // university entry on gate 1 with a university slot free
    is_vacated_space = 1'b0; uni_is_vacated_space = 1'b1;
    serve(1, 1'b1, 1'b0, 1'b1);

    // round-robin: all gates request continuously from reset
    do_reset();
    is_vacated_space = 1'b1; uni_is_vacated_space = 1'b1;
    gate_is_uni = '0; gate_is_exit = '0;
    gate_req = 4'hF;
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cyc = 0; prev = 0; n_ack = 0;
    while (cyc < 40 && n_ack < 5) begin
      @(posedge clk); #1;
      cyc++;
      if (gate_ack != '0) begin
        chk("rr_order", gate_ack, exp_q.pop_front());
        if (n_ack == 0) chk("rr_first_latency", cyc, 4);
        else            chk("rr_spacing", cyc - prev, 4);
        prev = cyc;
        n_ack++;
      end
    end
    if (n_ack < 5) chk("rr_timeout", n_ack, 5);
    gate_req = '0;

    // reset during the strobe of a gate 0 entry
    do_reset();
    is_vacated_space = 1'b1; uni_is_vacated_space = 1'b0;
    gate_req = 4'b0001; gate_is_uni = '0; gate_is_exit = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_strobe_before", car_entered, 1);
    reset = 1'b1;
    #1;
    chk("mid_strobe_dropped", car_entered, 0);
    chk("mid_busy", busy, 0);
    @(posedge clk); #1;
    chk("mid_no_ack", gate_ack, 0);
    chk("mid_denied", denied_count, 0);
    reset = 1'b0;
    serve(0, 1'b0, 1'b0, 1'b1);

    // saturation: 20 denied entries on a 4-bit counter
    do_reset();
    is_vacated_space = 1'b1; uni_is_vacated_space = 1'b0;
    for (int n = 0; n < 20; n++) begin
      serve(1, 1'b1, 1'b0, 1'b0);
      if (n == 14) chk("sat_reach", denied_count, 15);
    end
    chk("sat_hold", denied_count, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
